// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Free-running horizontal/vertical counters produce the pixel position, the
// visible-area qualifier and line/frame strobes with no added latency. The
// sync outputs are delayed through a short shift pipeline so they line up
// with the downstream pixel path. frame_tick is the game-logic update strobe
// and frame_cnt counts completed frames.
// Counter widths are 10 bits, so H_TOTAL and V_TOTAL must not exceed 1024.

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 32'd640,
    parameter int unsigned H_FP       = 32'd16,
    parameter int unsigned H_SYNC     = 32'd96,
    parameter int unsigned H_BP       = 32'd48,
    parameter int unsigned V_ACTIVE   = 32'd480,
    parameter int unsigned V_FP       = 32'd10,
    parameter int unsigned V_SYNC     = 32'd2,
    parameter int unsigned V_BP       = 32'd33,
    parameter int unsigned SYNC_DELAY = 32'd2
) (
    input  logic        clk_25m,
    input  logic        rst,
    output logic [9:0]  hc,
    output logic [9:0]  vc,
    output logic        valid,
    output logic        hsync,
    output logic        vsync,
    output logic        line_tick,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Out-of-range delays are clamped to the supported 1..4 stages.
    localparam int unsigned PIPE_DEPTH = (SYNC_DELAY < 32'd1) ? 32'd1 :
                                         ((SYNC_DELAY > 32'd4) ? 32'd4 : SYNC_DELAY);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 32'd1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 32'd1);
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]            hc_r;
    logic [9:0]            vc_r;
    logic [15:0]           frame_cnt_r;
    logic [PIPE_DEPTH-1:0] hsync_pipe_r;
    logic [PIPE_DEPTH-1:0] vsync_pipe_r;

    logic [9:0] hc_nxt_s;
    logic [9:0] vc_nxt_s;
    logic       valid_s;
    logic       line_tick_s;
    logic       frame_tick_s;
    logic       hsync_raw_s;
    logic       vsync_raw_s;

    // Strobes and visible-area qualifier decoded straight from the counters.
    always_comb begin
        line_tick_s  = 1'b0;
        frame_tick_s = 1'b0;
        valid_s      = 1'b0;
        if (hc_r == H_LAST) begin
            line_tick_s = 1'b1;
            if (vc_r == V_LAST) begin
                frame_tick_s = 1'b1;
            end else begin
                frame_tick_s = 1'b0;
            end
        end else begin
            line_tick_s  = 1'b0;
            frame_tick_s = 1'b0;
        end
        if ((hc_r < H_VIS) && (vc_r < V_VIS)) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
    end

    // Undelayed active-low sync windows.
    always_comb begin
        hsync_raw_s = 1'b1;
        vsync_raw_s = 1'b1;
        if ((hc_r >= H_SYNC_START) && (hc_r < H_SYNC_END)) begin
            hsync_raw_s = 1'b0;
        end else begin
            hsync_raw_s = 1'b1;
        end
        if ((vc_r >= V_SYNC_START) && (vc_r < V_SYNC_END)) begin
            vsync_raw_s = 1'b0;
        end else begin
            vsync_raw_s = 1'b1;
        end
    end

    // Next counter values: hc wraps every line, vc advances only on the last pixel.
    always_comb begin
        hc_nxt_s = hc_r + 10'd1;
        vc_nxt_s = vc_r;
        if (line_tick_s) begin
            hc_nxt_s = 10'd0;
            if (vc_r == V_LAST) begin
                vc_nxt_s = 10'd0;
            end else begin
                vc_nxt_s = vc_r + 10'd1;
            end
        end else begin
            hc_nxt_s = hc_r + 10'd1;
            vc_nxt_s = vc_r;
        end
    end

    // Position counters; reset restarts the raster at the top-left pixel.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            hc_r <= 10'd0;
            vc_r <= 10'd0;
        end else begin
            hc_r <= hc_nxt_s;
            vc_r <= vc_nxt_s;
        end
    end

    // Completed-frame counter; reset wins over a coincident frame end, wraps freely.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_tick_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Sync delay lines; reset fills them with the inactive level so no stale pulse leaks out.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            hsync_pipe_r <= {PIPE_DEPTH{1'b1}};
            vsync_pipe_r <= {PIPE_DEPTH{1'b1}};
        end else begin
            hsync_pipe_r <= (hsync_pipe_r << 32'd1) | PIPE_DEPTH'(hsync_raw_s);
            vsync_pipe_r <= (vsync_pipe_r << 32'd1) | PIPE_DEPTH'(vsync_raw_s);
        end
    end

    assign hc         = hc_r;
    assign vc         = vc_r;
    assign valid      = valid_s;
    assign line_tick  = line_tick_s;
    assign frame_tick = frame_tick_s;
    assign frame_cnt  = frame_cnt_r;
    assign hsync      = hsync_pipe_r[PIPE_DEPTH-1];
    assign vsync      = vsync_pipe_r[PIPE_DEPTH-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three full-size instances (sync delay 2, 1, 4)
// checked against a table of cycle-indexed vectors over the first two lines,
// plus a reduced-raster instance (16x10 totals) checked every cycle against
// a queued expected stream, which makes whole frames, mid-frame resets and
// frame counter wrap affordable.
`timescale 1ns/1ps

module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic        valid;
        logic        hsync;
        logic        vsync;
        logic        line_tick;
        logic        frame_tick;
        logic [15:0] fcnt;
    } obs_t;

    typedef struct {
        int         cyc;
        logic [9:0] hc;
        logic [9:0] vc;
        logic       valid;
        logic       lt;
        logic       hs2;
        logic       hs1;
        logic       hs4;
    } vec_t;

    localparam int SH_TOT = 16;
    localparam int SV_TOT = 10;
    localparam int SFRAME = 160;
    localparam int NV     = 17;

    logic clk_25m = 1'b0;
    logic rst     = 1'b1;

    logic [9:0]  def_hc, d1_hc, d4_hc, sm_hc;
    logic [9:0]  def_vc, d1_vc, d4_vc, sm_vc;
    logic        def_valid, d1_valid, d4_valid, sm_valid;
    logic        def_hsync, d1_hsync, d4_hsync, sm_hsync;
    logic        def_vsync, d1_vsync, d4_vsync, sm_vsync;
    logic        def_lt, d1_lt, d4_lt, sm_lt;
    logic        def_ft, d1_ft, d4_ft, sm_ft;
    logic [15:0] def_fc, d1_fc, d4_fc, sm_fc;

    obs_t def_o, d1_o, d4_o, sm_o;
    assign def_o = '{def_hc, def_vc, def_valid, def_hsync, def_vsync, def_lt, def_ft, def_fc};
    assign d1_o  = '{d1_hc, d1_vc, d1_valid, d1_hsync, d1_vsync, d1_lt, d1_ft, d1_fc};
    assign d4_o  = '{d4_hc, d4_vc, d4_valid, d4_hsync, d4_vsync, d4_lt, d4_ft, d4_fc};
    assign sm_o  = '{sm_hc, sm_vc, sm_valid, sm_hsync, sm_vsync, sm_lt, sm_ft, sm_fc};

    always #20 clk_25m = ~clk_25m;

    vga_timing_gen u_def (
        .clk_25m(clk_25m), .rst(rst), .hc(def_hc), .vc(def_vc), .valid(def_valid),
        .hsync(def_hsync), .vsync(def_vsync), .line_tick(def_lt),
        .frame_tick(def_ft), .frame_cnt(def_fc)
    );

    vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (
        .clk_25m(clk_25m), .rst(rst), .hc(d1_hc), .vc(d1_vc), .valid(d1_valid),
        .hsync(d1_hsync), .vsync(d1_vsync), .line_tick(d1_lt),
        .frame_tick(d1_ft), .frame_cnt(d1_fc)
    );

    vga_timing_gen #(.SYNC_DELAY(4)) u_d4 (
        .clk_25m(clk_25m), .rst(rst), .hc(d4_hc), .vc(d4_vc), .valid(d4_valid),
        .hsync(d4_hsync), .vsync(d4_vsync), .line_tick(d4_lt),
        .frame_tick(d4_ft), .frame_cnt(d4_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(2)
    ) u_sm (
        .clk_25m(clk_25m), .rst(rst), .hc(sm_hc), .vc(sm_vc), .valid(sm_valid),
        .hsync(sm_hsync), .vsync(sm_vsync), .line_tick(sm_lt),
        .frame_tick(sm_ft), .frame_cnt(sm_fc)
    );

    int          total   = 0;
    int          bad     = 0;
    int          m_cyc   = 0;
    logic        started = 1'b0;
    logic [15:0] m_fbase = 16'h0000;
    logic        hh[$];
    logic        vh[$];
    obs_t        sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: cycle=%0d got=%0h want=%0h", nm, m_cyc, act, exp);
        end
    endtask

    task automatic chk_obs(input string pfx, input obs_t a, input obs_t x);
        chk({pfx, ".hc"},         32'(a.hc),         32'(x.hc));
        chk({pfx, ".vc"},         32'(a.vc),         32'(x.vc));
        chk({pfx, ".valid"},      32'(a.valid),      32'(x.valid));
        chk({pfx, ".hsync"},      32'(a.hsync),      32'(x.hsync));
        chk({pfx, ".vsync"},      32'(a.vsync),      32'(x.vsync));
        chk({pfx, ".line_tick"},  32'(a.line_tick),  32'(x.line_tick));
        chk({pfx, ".frame_tick"}, 32'(a.frame_tick), 32'(x.frame_tick));
        chk({pfx, ".frame_cnt"},  32'(a.fcnt),       32'(x.fcnt));
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (m_cyc != target && n < 5000) begin
            @(negedge clk_25m);
            n++;
        end
        if (m_cyc != target) chk("wait_timeout", 32'(m_cyc), 32'(target));
    endtask

    // Expected reduced-raster state for the cycle each edge starts, from cycle arithmetic.
    always @(posedge clk_25m) begin : sb_push
        int   t;
        int   h;
        int   v;
        obs_t e;
        if (rst || started) begin
            if (rst) begin
                t  = 0;
                hh = '{1'b1, 1'b1};
                vh = '{1'b1, 1'b1};
            end else begin
                t = m_cyc + 1;
            end
            h            = t % SH_TOT;
            v            = (t / SH_TOT) % SV_TOT;
            e.hc         = 10'(h);
            e.vc         = 10'(v);
            e.valid      = (h < 8) && (v < 6);
            e.line_tick  = (h == SH_TOT - 1);
            e.frame_tick = (h == SH_TOT - 1) && (v == SV_TOT - 1);
            e.fcnt       = m_fbase + 16'(t / SFRAME);
            e.hsync      = hh.pop_front();
            hh.push_back(!((h >= 10) && (h < 13)));
            e.vsync      = vh.pop_front();
            vh.push_back(!((v >= 7) && (v < 9)));
            sb_q.push_back(e);
            m_cyc   <= t;
            started <= 1'b1;
        end
    end

    // Compare the reduced-raster instance against the queued expectation.
    always @(negedge clk_25m) begin : sb_pop
        obs_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_obs("sm", sm_o, e);
        end
    end

    initial begin : watchdog
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs[NV];
        obs_t x;
        int   idx;
        int   guard;
        int   low2;
        int   first1;
        int   first2;
        int   first4;
        int   vlow;
        int   vfirst;

        //            cyc    hc       vc     valid lt    hs2   hs1   hs4
        vecs[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{639,  10'd639, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{640,  10'd640, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{657,  10'd657, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{658,  10'd658, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{660,  10'd660, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{752,  10'd752, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{753,  10'd753, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{754,  10'd754, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{755,  10'd755, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{756,  10'd756, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{799,  10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{800,  10'd0,   10'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1439, 10'd639, 10'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1458, 10'd658, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1553, 10'd753, 10'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1554, 10'd754, 10'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        idx = 0; guard = 0; low2 = 0; vlow = 0;
        first1 = -1; first2 = -1; first4 = -1; vfirst = -1;

        repeat (3) @(negedge clk_25m);
        #1 rst = 1'b0;

        // First two lines of the full-size instances plus the first small frame.
        while (idx < NV && guard < 4000) begin
            if (m_cyc < 800) begin
                if (def_hsync === 1'b0) begin
                    low2++;
                    if (first2 < 0) first2 = m_cyc;
                end
                if (d1_hsync === 1'b0 && first1 < 0) first1 = m_cyc;
                if (d4_hsync === 1'b0 && first4 < 0) first4 = m_cyc;
            end
            if (m_cyc < SFRAME && sm_vsync === 1'b0) begin
                vlow++;
                if (vfirst < 0) vfirst = m_cyc;
            end
            if (m_cyc == 159) chk("sm frame_tick at 159", 32'(sm_ft), 32'd1);
            if (m_cyc == 160) begin
                chk("sm frame_cnt at 160", 32'(sm_fc), 32'd1);
                chk("sm hc at 160", 32'(sm_hc), 32'd0);
                chk("sm vc at 160", 32'(sm_vc), 32'd0);
            end
            if (m_cyc == vecs[idx].cyc) begin
                x = '{vecs[idx].hc, vecs[idx].vc, vecs[idx].valid, vecs[idx].hs2,
                      1'b1, vecs[idx].lt, 1'b0, 16'h0000};
                chk_obs("def", def_o, x);
                x.hsync = vecs[idx].hs1;
                chk_obs("d1", d1_o, x);
                x.hsync = vecs[idx].hs4;
                chk_obs("d4", d4_o, x);
                idx++;
            end
            @(negedge clk_25m);
            guard++;
        end
        if (idx < NV) chk("table_timeout", 32'(idx), 32'(NV));

        chk("def hsync low cycles line0", 32'(low2), 32'd96);
        chk("def hsync first low", 32'(first2), 32'd658);
        chk("d1 hsync first low", 32'(first1), 32'd657);
        chk("d4 hsync first low", 32'(first4), 32'd660);
        chk("sm vsync low cycles frame0", 32'(vlow), 32'd32);
        chk("sm vsync first low", 32'(vfirst), 32'd114);

        // Reset inside both sync pulses of the small raster.
        wait_cyc(1740);
        chk("pre-reset sm hsync", 32'(sm_hsync), 32'd0);
        chk("pre-reset sm vsync", 32'(sm_vsync), 32'd0);
        chk("pre-reset sm frame_cnt", 32'(sm_fc), 32'd10);
        #1 rst = 1'b1;
        @(negedge clk_25m);
        chk("mid rst sm hc", 32'(sm_hc), 32'd0);
        chk("mid rst sm vc", 32'(sm_vc), 32'd0);
        chk("mid rst sm hsync", 32'(sm_hsync), 32'd1);
        chk("mid rst sm vsync", 32'(sm_vsync), 32'd1);
        chk("mid rst sm frame_cnt", 32'(sm_fc), 32'd0);
        chk("mid rst def hc", 32'(def_hc), 32'd0);
        #1 rst = 1'b0;

        // Reset on a frame_tick cycle must not count the frame.
        wait_cyc(319);
        chk("pre-reset sm frame_tick", 32'(sm_ft), 32'd1);
        chk("pre-reset sm frame_cnt 1", 32'(sm_fc), 32'd1);
        #1 rst = 1'b1;
        @(negedge clk_25m);
        chk("tick rst sm frame_cnt", 32'(sm_fc), 32'd0);
        chk("tick rst sm hc", 32'(sm_hc), 32'd0);
        chk("tick rst sm vc", 32'(sm_vc), 32'd0);
        #1 rst = 1'b0;

        // Preload 0xFFFF into the frame counter and let one frame complete.
        wait_cyc(50);
        #1;
        force u_sm.frame_cnt_r = 16'hFFFF;
        m_fbase = 16'hFFFF;
        @(negedge clk_25m);
        #1;
        release u_sm.frame_cnt_r;
        wait_cyc(159);
        chk("preload frame_cnt", 32'(sm_fc), 32'h0000FFFF);
        wait_cyc(160);
        chk("wrap frame_cnt", 32'(sm_fc), 32'd0);
        wait_cyc(320);
        chk("after wrap frame_cnt", 32'(sm_fc), 32'd1);

        repeat (2) @(negedge clk_25m);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
